// File: rtl/aer_event_decoder.sv
// AER 2x2 receive decoder: per-channel spike pulses plus windowed event counts thresholded into a 4-bit pixel image.
// Optional feature: define AER_DEC_STATS_EN to enable the saturating event_total counter.
module aer_event_decoder #(
    parameter int unsigned WINDOW    = 64,
    parameter int unsigned WIN_W     = 8,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned THRESHOLD = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  aer_addr,
    input  logic        aer_valid,
    output logic        spike_out_0,
    output logic        spike_out_1,
    output logic        spike_out_2,
    output logic        spike_out_3,
    output logic [3:0]  pixel_out,
    output logic        pixel_valid,
    output logic [15:0] event_total
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        REPORT
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               accept;
    logic [3:0]         hit;
    logic [3:0]         spike;
    logic [WIN_W-1:0]   win_cnt;
    logic               win_last;
    logic [CNT_W-1:0]   cnt     [4];
    logic [CNT_W-1:0]   cnt_inc [4];
    logic [3:0]         pix_next;

    assign accept = enable && aer_valid;

    // aer_addr only reaches the decode under accept, so it cannot leak while aer_valid is low
    always_comb begin
        hit = '0;
        if (accept) begin
            hit = 4'b0001 << aer_addr;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            cnt_inc[i]  = (hit[i] && (cnt[i] != '1)) ? cnt[i] + 1'b1 : cnt[i];
            pix_next[i] = (cnt_inc[i] >= CNT_W'(THRESHOLD));
        end
    end

    assign win_last = (state == COLLECT) && (win_cnt == WIN_W'(WINDOW - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = COLLECT;
                COLLECT: if (win_last) state_next = REPORT;
                REPORT:  state_next = COLLECT;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        pixel_valid = (state == REPORT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spike     <= '0;
            win_cnt   <= '0;
            pixel_out <= '0;
            for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            spike <= hit;
            if (!enable || state == IDLE) begin
                win_cnt <= '0;
                for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
            end else if (state == COLLECT) begin
                if (win_last) begin
                    pixel_out <= pix_next;
                    win_cnt   <= '0;
                    for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
                end else begin
                    win_cnt <= win_cnt + 1'b1;
                    for (int unsigned i = 0; i < 4; i++) cnt[i] <= cnt_inc[i];
                end
            end else begin
                // REPORT: counts restart, but an event arriving now opens the next window
                win_cnt <= '0;
                for (int unsigned i = 0; i < 4; i++) cnt[i] <= CNT_W'(hit[i]);
            end
        end
    end

    assign spike_out_0 = spike[0];
    assign spike_out_1 = spike[1];
    assign spike_out_2 = spike[2];
    assign spike_out_3 = spike[3];

`ifdef AER_DEC_STATS_EN
    logic [15:0] total;

    always_ff @(posedge clk) begin
        if (rst) begin
            total <= '0;
        end else if (accept && (total != 16'hFFFF)) begin
            total <= total + 1'b1;
        end
    end

    assign event_total = total;
`else
    assign event_total = 16'h0000;
`endif

endmodule

// File: tb/tb_aer_event_decoder.sv
// Directed bench for aer_event_decoder: a default-parameter instance and a small-window, 4-bit-count, threshold-1 instance.
module tb_aer_event_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, v_a, en_b, v_b;
    logic [1:0]  addr_a, addr_b;
    logic [3:0]  spk_a, spk_b, px_a, px_b;
    logic        pv_a, pv_b;
    logic [15:0] tot_a, tot_b;

    int          checks = 0;
    int          errors = 0;
    int unsigned exp_total = 0;

    aer_event_decoder #(.WINDOW(64), .WIN_W(8), .CNT_W(8), .THRESHOLD(2)) dut_a (
        .clk(clk), .rst(rst), .enable(en_a), .aer_addr(addr_a), .aer_valid(v_a),
        .spike_out_0(spk_a[0]), .spike_out_1(spk_a[1]), .spike_out_2(spk_a[2]), .spike_out_3(spk_a[3]),
        .pixel_out(px_a), .pixel_valid(pv_a), .event_total(tot_a)
    );

    aer_event_decoder #(.WINDOW(32), .WIN_W(6), .CNT_W(4), .THRESHOLD(1)) dut_b (
        .clk(clk), .rst(rst), .enable(en_b), .aer_addr(addr_b), .aer_valid(v_b),
        .spike_out_0(spk_b[0]), .spike_out_1(spk_b[1]), .spike_out_2(spk_b[2]), .spike_out_3(spk_b[3]),
        .pixel_out(px_b), .pixel_valid(pv_b), .event_total(tot_b)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle on instance b (1) or a (0), then check its spike pulse
    task automatic step(input bit b, input logic en, input logic v, input logic [1:0] a);
        logic [1:0] ad;
        ad = v ? a : 2'($urandom_range(3));
        if (b) begin
            en_b = en; v_b = v; addr_b = ad;
        end else begin
            en_a = en; v_a = v; addr_a = ad;
        end
        @(posedge clk);
        #1;
        if (!b && en && v) exp_total++;
        check(b ? "spike_b" : "spike_a", {28'd0, b ? spk_b : spk_a},
              (en && v) ? {28'd0, 4'b0001 << a} : 32'd0);
    endtask

    // Event stimulus for cycle k of a run: {valid, addr}
    function automatic logic [2:0] pick(input int mode, input int k);
        logic [2:0] e;
        e = 3'b000;
        case (mode)
            1: if (k % 5 == 0) e = 3'b100;
            2: begin
                if      (k % 5 == 0)  e = 3'b100;
                else if (k % 7 == 0)  e = 3'b101;
                else if (k % 11 == 0) e = 3'b110;
                else if (k % 13 == 0) e = 3'b111;
            end
            3: begin
                if      (k % 5 == 0)  e = 3'b100;
                else if (k % 7 == 0)  e = 3'b101;
                else if (k % 11 == 0) e = 3'b110;
                else if (k == 13)     e = 3'b111;
            end
            4: begin
                if (k == 30 || k == 65)       e = 3'b101;
                else if (k == 66 || k == 100) e = 3'b110;
            end
            6: if (k % 3 == 0) e = 3'b100;
            7: begin
                if (k == 10 || k == 20) e = 3'b111;
                else if (k == 15)       e = 3'b100;
            end
            8: begin
                if (k >= 2 && k <= 33) e = 3'b110;
                else if (k == 34)      e = 3'b101;
            end
            default: e = 3'b000;
        endcase
        return e;
    endfunction

    // Run n enabled cycles from IDLE; pixel_valid expected only at cycles pv1/pv2
    task automatic run(input bit b, input int mode, input int n, input int pv1, input int pv2,
                       input logic [3:0] px1, input logic [3:0] px2, input string tag);
        logic [2:0] e;
        for (int k = 1; k <= n; k++) begin
            e = pick(mode, k);
            step(b, 1'b1, e[2], e[1:0]);
            check({tag, " pixel_valid"}, {31'd0, b ? pv_b : pv_a}, {31'd0, (k == pv1 || k == pv2)});
            if (k == pv1) check({tag, " pixel_out 1"}, {28'd0, b ? px_b : px_a}, {28'd0, px1});
            if (k == pv2) check({tag, " pixel_out 2"}, {28'd0, b ? px_b : px_a}, {28'd0, px2});
        end
    endtask

    // Disabled cycles with ignored strobes: no report, pixel_out held
    task automatic idle(input int n, input logic [3:0] hold, input string tag);
        for (int k = 0; k < n; k++) begin
            step(1'b0, 1'b0, 1'($urandom), 2'($urandom));
            check({tag, " pixel_valid"}, {31'd0, pv_a}, 32'd0);
            check({tag, " pixel_out"}, {28'd0, px_a}, {28'd0, hold});
        end
    endtask

    initial begin
        rst = 1'b1;
        en_a = 1'b1; en_b = 1'b1;
        v_a = 1'b0; v_b = 1'b0; addr_a = '0; addr_b = '0;
        repeat (3) begin
            v_a = 1'($urandom); addr_a = 2'($urandom);
            v_b = 1'($urandom); addr_b = 2'($urandom);
            @(posedge clk);
            #1;
            check("rst spikes", {28'd0, spk_a}, 32'd0);
            check("rst pixel_out", {28'd0, px_a}, 32'd0);
            check("rst pixel_valid", {31'd0, pv_a}, 32'd0);
            check("rst event_total", {16'd0, tot_a}, 32'd0);
            check("rst pixel_valid b", {31'd0, pv_b}, 32'd0);
        end
        rst = 1'b0;
        en_b = 1'b0; v_b = 1'b0;
        idle(65, 4'b0000, "post-reset");

        run(1'b0, 1, 131, 65, 130, 4'b0001, 4'b0001, "single ch0");
        check("hold after report", {28'd0, px_a}, 32'h1);

        idle(2, 4'b0001, "restart");
        run(1'b0, 2, 65, 65, 0, 4'b1111, 4'b0000, "all channels");

        idle(2, 4'b1111, "restart");
        run(1'b0, 3, 65, 65, 0, 4'b0111, 4'b0000, "single ch3");

        idle(2, 4'b0111, "restart");
        run(1'b0, 4, 130, 65, 130, 4'b0010, 4'b0100, "boundary");

        idle(2, 4'b0100, "restart");
        run(1'b0, 6, 31, 0, 0, 4'b0000, 4'b0000, "pre-abort");
        idle(70, 4'b0100, "abort");
        run(1'b0, 7, 65, 65, 0, 4'b1000, 4'b0000, "re-enable");

`ifdef AER_DEC_STATS_EN
        check("event_total", {16'd0, tot_a}, exp_total);
`else
        check("event_total", {16'd0, tot_a}, 32'd0);
`endif

        run(1'b1, 8, 66, 33, 66, 4'b0100, 4'b0010, "saturation b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
